// File: rtl/seg7_scan_display_if.sv
// rtl/seg7_scan_display_if.sv - core-side value bus and display pins of seg7_scan_display
interface seg7_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 32
);
  logic [DATA_W-1:0]     value_in;
  logic                  load;
  logic                  hex_mode;
  logic                  blank_lz;
  logic [0:6]            seg;
  logic [NUM_DIGITS-1:0] digit;
  logic                  busy;
  logic                  overflow;

  modport master (
    output value_in, load, hex_mode, blank_lz,
    input  seg, digit, busy, overflow
  );

  modport slave (
    input  value_in, load, hex_mode, blank_lz,
    output seg, digit, busy, overflow
  );
endinterface

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - value capture, double-dabble/hex conversion and multiplexed 7-segment scan
module seg7_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 32,
  parameter int CLK_HZ     = 100000000,
  parameter int SAMPLE_HZ  = 10,
  parameter int REFRESH_HZ = 1000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_display_if.slave bus
);
  localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DIGIT_DIV  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int DISP_W     = 4 * NUM_DIGITS;
  localparam int BCD_W      = DISP_W + 4;
  localparam int EXT_W      = (DATA_W > DISP_W) ? DATA_W : DISP_W;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP_W     = $clog2(DATA_W);

  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                state, state_d;
  logic [31:0]           sample_cnt, digit_cnt;
  logic                  sample_tick, digit_tick, capture;
  logic [IDX_W-1:0]      scan_idx, scan_idx_d;
  logic                  pending, pending_d;
  logic [DATA_W-1:0]     bin, bin_d;
  logic [BCD_W-1:0]      bcd, bcd_d, adj, step_bcd;
  logic                  lost, lost_d, step_lost;
  logic [STEP_W-1:0]     step, step_d;
  logic                  blz_q, blz_d;
  logic [DISP_W-1:0]     disp_nib, disp_nib_d;
  logic [NUM_DIGITS-1:0] disp_blank, disp_blank_d;
  logic                  ovf_q, ovf_d;
  logic [EXT_W-1:0]      ext;
  logic                  hex_ovf;
  logic [0:6]            seg_d;
  logic [NUM_DIGITS-1:0] digit_d;
  logic [3:0]            scan_nib;

  function automatic logic [0:6] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i <= NUM_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A digit is dark only when it and everything above it is zero; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DISP_W-1:0] nib, input logic en);
    logic [NUM_DIGITS-1:0] m;
    logic                  above;
    m     = '0;
    above = en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      above = above & (nib[4*i +: 4] == 4'd0);
      m[i]  = above;
    end
    return m;
  endfunction

  assign sample_tick  = (sample_cnt == 32'(SAMPLE_DIV - 1));
  assign digit_tick   = (digit_cnt == 32'(DIGIT_DIV - 1));
  assign capture      = sample_tick | bus.load;
  assign ext          = EXT_W'(bus.value_in);
  assign hex_ovf      = ((ext >> DISP_W) != '0);
  assign bus.overflow = ovf_q;

  always_comb begin
    state_d      = state;
    pending_d    = pending;
    bin_d        = bin;
    bcd_d        = bcd;
    lost_d       = lost;
    step_d       = step;
    blz_d        = blz_q;
    disp_nib_d   = disp_nib;
    disp_blank_d = disp_blank;
    ovf_d        = ovf_q;
    // Bits leaving the extra top nibble are kept sticky so wide inputs still flag overflow.
    adj          = add3(bcd);
    step_bcd     = {adj[BCD_W-2:0], bin[DATA_W-1]};
    step_lost    = lost | adj[BCD_W-1];
    case (state)
      IDLE: begin
        if (capture || pending) begin
          pending_d = 1'b0;
          if (bus.hex_mode) begin
            disp_nib_d   = ext[DISP_W-1:0];
            disp_blank_d = lz_mask(ext[DISP_W-1:0], bus.blank_lz);
            ovf_d        = hex_ovf;
            state_d      = COMMIT;
          end else begin
            bin_d   = bus.value_in;
            bcd_d   = '0;
            lost_d  = 1'b0;
            step_d  = '0;
            blz_d   = bus.blank_lz;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        pending_d = pending | capture;
        bin_d     = {bin[DATA_W-2:0], 1'b0};
        bcd_d     = step_bcd;
        lost_d    = step_lost;
        step_d    = step + 1'b1;
        if (step == STEP_W'(DATA_W - 1)) begin
          disp_nib_d   = step_bcd[DISP_W-1:0];
          disp_blank_d = lz_mask(step_bcd[DISP_W-1:0], blz_q);
          ovf_d        = step_lost | (step_bcd[BCD_W-1 -: 4] != 4'd0);
          state_d      = COMMIT;
        end
      end
      COMMIT: begin
        pending_d = pending | capture;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Segments are taken from the next display value so they never lag a commit.
  always_comb begin
    scan_idx_d = scan_idx;
    if (digit_tick) scan_idx_d = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    scan_nib = disp_nib_d[{scan_idx_d, 2'b00} +: 4];
    digit_d  = ~(NUM_DIGITS'(1) << scan_idx_d);
    if (ovf_d)                         seg_d = SEG_DASH;
    else if (disp_blank_d[scan_idx_d]) seg_d = SEG_BLANK;
    else                               seg_d = glyph(scan_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      digit_cnt  <= '0;
      scan_idx   <= '0;
      pending    <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      lost       <= 1'b0;
      step       <= '0;
      blz_q      <= 1'b0;
      disp_nib   <= '0;
      disp_blank <= '0;
      ovf_q      <= 1'b0;
      bus.seg    <= SEG_BLANK;
      bus.digit  <= '1;
      bus.busy   <= 1'b0;
    end else begin
      state      <= state_d;
      sample_cnt <= sample_tick ? '0 : sample_cnt + 32'd1;
      digit_cnt  <= digit_tick ? '0 : digit_cnt + 32'd1;
      scan_idx   <= scan_idx_d;
      pending    <= pending_d;
      bin        <= bin_d;
      bcd        <= bcd_d;
      lost       <= lost_d;
      step       <= step_d;
      blz_q      <= blz_d;
      disp_nib   <= disp_nib_d;
      disp_blank <= disp_blank_d;
      ovf_q      <= ovf_d;
      bus.seg    <= seg_d;
      bus.digit  <= digit_d;
      bus.busy   <= (state_d == CONV);
    end
  end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display
module tb_seg7_scan_display;
  localparam int N          = 4;
  localparam int DW         = 32;
  localparam int CLK_HZ     = 1000;
  localparam int SAMPLE_HZ  = 10;
  localparam int REFRESH_HZ = 50;
  localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DIGIT_DIV  = CLK_HZ / (REFRESH_HZ * N);
  localparam int SYM_DASH   = 16;
  localparam int SYM_BLANK  = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_display_if #(.NUM_DIGITS(N), .DATA_W(DW)) bus ();

  seg7_scan_display #(
    .NUM_DIGITS(N), .DATA_W(DW), .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .REFRESH_HZ(REFRESH_HZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: timestamps in cycles since the last reset cycle.
  bit   m_valid = 1'b0;
  int   m_age, m_ready_at, m_show_at, busy_lo, busy_hi;
  bit   m_pend, m_ovf, n_ovf;
  int   m_sym [N];
  int   n_sym [N];
  logic [0:6]   e_seg;
  logic [N-1:0] e_digit;
  logic         e_busy, e_ovf;

  function automatic logic [0:6] glyph(input int s);
    string      lit;
    logic [0:6] g;
    case (s)
      0: lit = "abcdef";   1: lit = "bc";      2: lit = "abdeg";   3: lit = "abcdg";
      4: lit = "bcfg";     5: lit = "acdfg";   6: lit = "acdefg";  7: lit = "abc";
      8: lit = "abcdefg";  9: lit = "abcdfg";  10: lit = "abcefg"; 11: lit = "cdefg";
      12: lit = "adef";    13: lit = "bcdeg";  14: lit = "adefg";  15: lit = "aefg";
      16: lit = "g";
      default: lit = "";
    endcase
    g = '1;
    for (int i = 0; i < lit.len(); i++) g[int'(lit[i]) - 97] = 1'b0;
    return g;
  endfunction

  task automatic calc(input longint v, input bit hx, input bit blz);
    longint p;
    p = 1;
    if (hx) begin
      n_ovf = ((v >> (4 * N)) != 0);
      for (int i = 0; i < N; i++) n_sym[i] = int'((v >> (4 * i)) & 15);
    end else begin
      for (int i = 0; i < N; i++) begin
        n_sym[i] = int'((v / p) % 10);
        p = p * 10;
      end
      n_ovf = (v >= p);
    end
    if (blz)
      for (int i = N - 1; i >= 1; i--)
        if (n_sym[i] == 0 && (i == N - 1 || n_sym[i+1] == SYM_BLANK)) n_sym[i] = SYM_BLANK;
    if (n_ovf) for (int i = 0; i < N; i++) n_sym[i] = SYM_DASH;
  endtask

  task automatic model_step();
    int  t, idx;
    bit  cap;
    if (rst) begin
      m_valid = 1'b1; m_age = 0; m_pend = 1'b0; m_ready_at = 0; m_show_at = -1;
      busy_lo = 1; busy_hi = 0; m_ovf = 1'b0;
      for (int i = 0; i < N; i++) m_sym[i] = 0;
      e_seg = 7'h7F; e_digit = '1; e_busy = 1'b0; e_ovf = 1'b0;
    end else if (m_valid) begin
      t   = m_age;
      cap = bus.load || (t % SAMPLE_DIV == SAMPLE_DIV - 1);
      if (t < m_ready_at) begin
        if (cap) m_pend = 1'b1;
      end else if (cap || m_pend) begin
        m_pend = 1'b0;
        calc(longint'(bus.value_in), bus.hex_mode, bus.blank_lz);
        if (bus.hex_mode) begin
          m_show_at = t + 1; m_ready_at = t + 2;
        end else begin
          busy_lo = t + 1; busy_hi = t + DW; m_show_at = t + DW + 1; m_ready_at = t + DW + 2;
        end
      end
      m_age = t + 1;
      if (m_age == m_show_at) begin
        m_sym = n_sym;
        m_ovf = n_ovf;
      end
      idx     = (m_age / DIGIT_DIV) % N;
      e_digit = ~(N'(1) << idx);
      e_seg   = glyph(m_sym[idx]);
      e_busy  = (m_age >= busy_lo) && (m_age <= busy_hi);
      e_ovf   = m_ovf;
    end
  endtask

  // One clock: model advances on the edge, every output is compared half a cycle later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_valid) begin
      tests++;
      if (bus.seg !== e_seg || bus.digit !== e_digit || bus.busy !== e_busy || bus.overflow !== e_ovf) begin
        fails++;
        $display("FAIL model age=%0d: got seg=%b digit=%b busy=%b ovf=%b, want seg=%b digit=%b busy=%b ovf=%b",
                 m_age, bus.seg, bus.digit, bus.busy, bus.overflow, e_seg, e_digit, e_busy, e_ovf);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_seg(input string name, input logic [0:6] got, input logic [0:6] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got seg=%b want seg=%b", name, got, want);
    end
  endtask

  task automatic seg_at(input int i, input logic [0:6] want, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 4 * N * DIGIT_DIV && !ok; k++) begin
      if (bus.digit == ~(N'(1) << i)) ok = 1'b1;
      else cyc();
    end
    if (!ok) check({name, "_scan_timeout"}, 32'(bus.digit), 32'(~(N'(1) << i)));
    else     check_seg(name, bus.seg, want);
  endtask

  // Start loads early in a sample period so auto-samples cannot overlap the directed checks.
  task automatic sync_phase();
    bit ok = 1'b0;
    for (int k = 0; k < 3 * SAMPLE_DIV && !ok; k++) begin
      if (m_age % SAMPLE_DIV == 40 && m_age >= m_ready_at && !bus.busy) ok = 1'b1;
      else cyc();
    end
    if (!ok) check("sync_timeout", 32'(m_age % SAMPLE_DIV), 32'd40);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 2 * DW && bus.busy; k++) cyc();
    if (bus.busy) check({name, "_idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_load(input logic [DW-1:0] v, input logic hx, input logic blz);
    bus.value_in = v; bus.hex_mode = hx; bus.blank_lz = blz; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.value_in = 32'hFFFFFFFF; bus.hex_mode = 1'b0; bus.blank_lz = 1'b0; bus.load = 1'b0;
    cyc();
    cyc();
    check_seg("reset_seg", bus.seg, 7'h7F);
    check("reset_digit", 32'(bus.digit), 32'hF);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    cyc();
    check("first_lit_digit", 32'(bus.digit), 32'b1110);
    check_seg("first_lit_seg", bus.seg, 7'b0000001);

    sync_phase();
    do_load(32'd1234, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 2 * DW && bus.busy; k++) begin n++; cyc(); end
    check("busy_len_1234", 32'(n), 32'd32);
    check("ovf_1234", 32'(bus.overflow), 32'd0);
    seg_at(0, 7'b1001100, "d0_4");
    seg_at(1, 7'b0000110, "d1_3");
    seg_at(2, 7'b0010010, "d2_2");
    seg_at(3, 7'b1001111, "d3_1");

    sync_phase();
    do_load(32'd42, 1'b0, 1'b1);
    wait_idle("lz42");
    seg_at(0, 7'b0010010, "lz_d0_2");
    seg_at(1, 7'b1001100, "lz_d1_4");
    seg_at(2, 7'h7F, "lz_d2_blank");
    seg_at(3, 7'h7F, "lz_d3_blank");

    sync_phase();
    do_load(32'd10000, 1'b0, 1'b0);
    wait_idle("ovf10000");
    check("ovf_10000", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < N; i++) seg_at(i, 7'b1111110, "dash_10000");
    sync_phase();
    do_load(32'd9999, 1'b0, 1'b0);
    wait_idle("9999");
    check("ovf_9999", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < N; i++) seg_at(i, 7'b0000100, "nine_9999");

    sync_phase();
    do_load(32'h0000BEEF, 1'b1, 1'b0);
    check("hex_busy_c1", 32'(bus.busy), 32'd0);
    check("hex_ovf_c1", 32'(bus.overflow), 32'd0);
    cyc();
    check("hex_busy_c2", 32'(bus.busy), 32'd0);
    seg_at(0, 7'b0111000, "hex_d0_F");
    seg_at(1, 7'b0110000, "hex_d1_E");
    seg_at(2, 7'b0110000, "hex_d2_E");
    seg_at(3, 7'b1100000, "hex_d3_b");
    sync_phase();
    do_load(32'h0001BEEF, 1'b1, 1'b0);
    check("hex17_ovf_c1", 32'(bus.overflow), 32'd1);
    check_seg("hex17_dash_c1", bus.seg, 7'b1111110);
    check("hex17_busy_c1", 32'(bus.busy), 32'd0);

    sync_phase();
    do_load(32'd5678, 1'b0, 1'b0);
    repeat (5) cyc();
    do_load(32'd321, 1'b0, 1'b0);
    wait_idle("pend_first");
    check("pend_commit_busy", 32'(bus.busy), 32'd0);
    cyc();
    check("pend_idle_busy", 32'(bus.busy), 32'd0);
    cyc();
    check("pend_serviced_busy", 32'(bus.busy), 32'd1);
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ovf", 32'(bus.overflow), 32'd0);
    check_seg("abort_seg", bus.seg, 7'h7F);
    check("abort_digit", 32'(bus.digit), 32'hF);
    n = 0;
    for (int k = 0; k < 2 * DW; k++) begin cyc(); if (bus.busy) n++; end
    check("abort_no_conv", 32'(n), 32'd0);
    for (int i = 0; i < N; i++) seg_at(i, 7'b0000001, "abort_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
